// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Requester-side controller for a shared single-port instruction/data memory.
// The memory has a synchronous write and a registered read. Its read data holds
// in any cycle where a write is performed. This block arbitrates between
// instruction fetch and data access, and data has priority. It turns byte
// addresses into word addresses and sequences the one-cycle read latency. It
// performs read-modify-write for byte and halfword stores, and it extracts and
// extends sub-word loads.
//
// Ports
//   clk, rst            system clock; synchronous active-high reset
//   if_req/if_addr      fetch request (held until if_ack), word-aligned byte address
//   if_ack/if_data      one-cycle completion pulse with fetched word
//   d_req/d_we/d_size   data request (held until d_ack), store flag, size
//                       (00 byte, 01 half, 1x word)
//   d_signed            sign-extend sub-word loads
//   d_addr/d_wdata      data byte address, right-justified store data
//   d_ack/d_rdata/d_err one-cycle completion pulse, load result, misalignment flag
//   mem_we/mem_addr/mem_din  registered memory write enable, word address, write data
//   mem_dout            memory read data (valid the cycle after the address is presented)
//   dbg_state           current FSM state (IDLE=0, ISSUE=1, WAIT=2, WRITE=3)
//
// Handshake: a requester raises *_req with stable operands and holds it until
// it sees the matching one-cycle *_ack. A request that is still visible in the
// ack cycle is ignored, so it is never serviced twice.
module mem_access_ctrl #(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ack,
  output logic [31:0]       if_data,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_signed,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_din_q, mem_din_d;
  logic                if_ack_q, if_ack_d;
  logic [31:0]         if_data_q, if_data_d;
  logic                d_ack_q, d_ack_d;
  logic                d_err_q, d_err_d;
  logic [31:0]         d_rdata_q, d_rdata_d;

  // Context of the access in flight
  logic                is_data_q, is_data_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                sgn_q, sgn_d;
  logic [1:0]          off_q, off_d;
  logic [31:0]         wdata_q, wdata_d;

  // Address bits beyond the memory size alias (wrap), and fetches are word-aligned.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0], d_addr[31:ADDR_W+2]};

  logic        d_misaligned;
  logic [4:0]  lane_shift;
  logic [31:0] lane_data;
  logic [31:0] load_val;
  logic [31:0] merge_mask;
  logic [31:0] merge_data;

  // Halfword needs bit 0 clear. A word (size 10 or 11) needs both low bits clear.
  assign d_misaligned = (d_size == 2'b01) ? d_addr[0] :
                        (d_size[1] ? (d_addr[1:0] != 2'b00) : 1'b0);

  // Halfword offsets are always even, so one byte-lane shift serves both sizes.
  assign lane_shift = {off_q, 3'b000};
  assign lane_data  = mem_dout >> lane_shift;

  always_comb begin
    load_val   = mem_dout;
    merge_mask = 32'hFFFF_FFFF;
    merge_data = wdata_q;
    case (size_q)
      2'b00: begin
        load_val   = {{24{sgn_q & lane_data[7]}}, lane_data[7:0]};
        merge_mask = 32'h0000_00FF << lane_shift;
        merge_data = {24'h0, wdata_q[7:0]} << lane_shift;
      end
      2'b01: begin
        load_val   = {{16{sgn_q & lane_data[15]}}, lane_data[15:0]};
        merge_mask = 32'h0000_FFFF << lane_shift;
        merge_data = {16'h0, wdata_q[15:0]} << lane_shift;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      if_ack_q   <= 1'b0;
      if_data_q  <= '0;
      d_ack_q    <= 1'b0;
      d_err_q    <= 1'b0;
      d_rdata_q  <= '0;
      is_data_q  <= 1'b0;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      sgn_q      <= 1'b0;
      off_q      <= 2'b00;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      if_ack_q   <= if_ack_d;
      if_data_q  <= if_data_d;
      d_ack_q    <= d_ack_d;
      d_err_q    <= d_err_d;
      d_rdata_q  <= d_rdata_d;
      is_data_q  <= is_data_d;
      we_q       <= we_d;
      size_q     <= size_d;
      sgn_q      <= sgn_d;
      off_q      <= off_d;
      wdata_q    <= wdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    if_ack_d   = 1'b0;
    if_data_d  = if_data_q;
    d_ack_d    = 1'b0;
    d_err_d    = 1'b0;
    d_rdata_d  = d_rdata_q;
    is_data_d  = is_data_q;
    we_d       = we_q;
    size_d     = size_q;
    sgn_d      = sgn_q;
    off_d      = off_q;
    wdata_d    = wdata_q;

    case (state_q)
      IDLE: begin
        // A request still held during its own ack cycle must not restart.
        if (!if_ack_q && !d_ack_q) begin
          if (d_req) begin
            is_data_d = 1'b1;
            we_d      = d_we;
            size_d    = d_size;
            sgn_d     = d_signed;
            off_d     = d_addr[1:0];
            wdata_d   = d_wdata;
            if (d_misaligned) begin
              d_ack_d = 1'b1;
              d_err_d = 1'b1;
            end else begin
              mem_addr_d = d_addr[ADDR_W+1:2];
              if (d_we && d_size[1]) begin
                mem_we_d  = 1'b1;
                mem_din_d = d_wdata;
                state_d   = WRITE;
              end else begin
                state_d = ISSUE;
              end
            end
          end else if (if_req) begin
            is_data_d  = 1'b0;
            we_d       = 1'b0;
            mem_addr_d = if_addr[ADDR_W+1:2];
            state_d    = ISSUE;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (is_data_q && we_q) begin
          mem_din_d = (mem_dout & ~merge_mask) | (merge_data & merge_mask);
          mem_we_d  = 1'b1;
          state_d   = WRITE;
        end else begin
          if (is_data_q) begin
            d_rdata_d = load_val;
            d_ack_d   = 1'b1;
          end else begin
            if_data_d = mem_dout;
            if_ack_d  = 1'b1;
          end
          state_d = IDLE;
        end
      end
      WRITE: begin
        d_ack_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign if_ack    = if_ack_q;
  assign if_data   = if_data_q;
  assign d_ack     = d_ack_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;
  localparam int AW = 13;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic          if_req = 1'b0;
  logic [31:0]   if_addr = '0;
  logic          if_ack;
  logic [31:0]   if_data;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [1:0]    d_size = 2'b00;
  logic          d_signed = 1'b0;
  logic [31:0]   d_addr = '0;
  logic [31:0]   d_wdata = '0;
  logic          d_ack;
  logic [31:0]   d_rdata;
  logic          d_err;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din;
  logic [31:0]   mem_dout = '0;
  logic [1:0]    dbg_state;

  mem_access_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_signed(d_signed),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .dbg_state(dbg_state)
  );

  // Memory array: synchronous write, registered read that holds while writing, no reset.
  logic [31:0] mem_arr [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) mem_arr[mem_addr] <= mem_din;
    else        mem_dout <= mem_arr[mem_addr];
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [0:(1<<AW)-1];

  function automatic logic ref_misaligned(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd1) return addr[0];
    if (size >= 2'd2) return (addr % 4) != 0;
    return 1'b0;
  endfunction

  function automatic int unsigned ref_widx(input logic [31:0] addr);
    return (addr / 4) % (1 << AW);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] size,
                                           input logic sgn, input logic [31:0] addr);
    longint unsigned v;
    int unsigned bytes;
    bytes = (size == 0) ? 1 : (size == 1) ? 2 : 4;
    if (bytes == 4) return word;
    v = (longint'(word) >> (8 * (addr % 4))) % (longint'(1) << (8 * bytes));
    if (sgn && v >= (longint'(1) << (8 * bytes - 1))) v = v + 64'h1_0000_0000 - (longint'(1) << (8 * bytes));
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [1:0] size,
                                            input logic [31:0] addr, input logic [31:0] wdata);
    longint unsigned lane, keep, newv;
    int unsigned bytes;
    bytes = (size == 0) ? 1 : (size == 1) ? 2 : 4;
    if (bytes == 4) return wdata;
    lane = (longint'(1) << (8 * bytes)) - 1;
    lane = lane << (8 * (addr % 4));
    keep = longint'(word) & ~lane;
    newv = ((longint'(wdata) % (longint'(1) << (8 * bytes))) << (8 * (addr % 4)));
    return 32'(keep | newv);
  endfunction

  // ---------------- scoreboard / monitor ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  int we_cnt = 0;
  int overlap_cnt = 0;
  int long_pulse_cnt = 0;
  logic [AW-1:0] last_we_addr;
  logic [31:0]   last_we_din;
  logic prev_if_ack = 1'b0, prev_d_ack = 1'b0;
  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt++;
      last_we_addr = mem_addr;
      last_we_din  = mem_din;
    end
    if (if_ack && d_ack) overlap_cnt++;
    if ((if_ack && prev_if_ack) || (d_ack && prev_d_ack)) long_pulse_cnt++;
    prev_if_ack = if_ack;
    prev_d_ack  = d_ack;
  end

  // ---------------- driver tasks ----------------
  task automatic exec_data(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int lat, output logic [31:0] rd, output logic err,
                           output int we_delta);
    int we0;
    @(posedge clk); #1;
    we0 = we_cnt;
    d_we = we; d_size = size; d_signed = sgn; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
    lat = -1; rd = '0; err = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (d_ack) begin
        lat = c; rd = d_rdata; err = d_err;
        break;
      end
    end
    d_req = 1'b0;
    #1 we_delta = we_cnt - we0;
  endtask

  task automatic exec_fetch(input logic [31:0] addr, output int lat, output logic [31:0] data,
                            output int we_delta);
    int we0;
    @(posedge clk); #1;
    we0 = we_cnt;
    if_addr = addr; if_req = 1'b1;
    lat = -1; data = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (if_ack) begin
        lat = c; data = if_data;
        break;
      end
    end
    if_req = 1'b0;
    #1 we_delta = we_cnt - we0;
  endtask

  // Runs one data access, checking it against the model, and keeps ref_mem in step.
  task automatic model_data(input string tag, input logic we, input logic [1:0] size,
                            input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                            inout logic [31:0] last_rd);
    int lat, wd, exp_lat;
    logic [31:0] rd, exp_word;
    logic err, exp_err;
    int unsigned wi;
    wi = ref_widx(addr);
    exp_err = ref_misaligned(size, addr);
    exp_lat = exp_err ? 1 : (we ? ((size >= 2) ? 2 : 4) : 3);
    exec_data(we, size, sgn, addr, wdata, lat, rd, err, wd);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " d_err"}, {31'b0, err}, {31'b0, exp_err});
    chk({tag, " we pulses"}, 32'(wd), (we && !exp_err) ? 32'd1 : 32'd0);
    if (exp_err) begin
      chk({tag, " rdata held"}, rd, last_rd);
    end else if (we) begin
      exp_word = ref_store(ref_mem[wi], size, addr, wdata);
      ref_mem[wi] = exp_word;
      chk({tag, " mem_addr"}, 32'(last_we_addr), 32'(wi));
      chk({tag, " mem_din"}, last_we_din, exp_word);
    end else begin
      exp_q.push_back(ref_load(ref_mem[wi], size, sgn, addr));
      last_rd = exp_q.pop_front();
      chk({tag, " rdata"}, rd, last_rd);
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    vec_t v;
    v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_lat = exp_lat;
    return v;
  endfunction

  initial begin
    vec_t vecs [$];
    int lat, wd, ilat, dlat, abort_acks, we0;
    logic [31:0] rd, fd, last_rd;
    logic err;

    vecs.push_back(mk(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 2));
    vecs.push_back(mk(0, 2'd2, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 3));
    vecs.push_back(mk(0, 2'd0, 1, 32'h13, 32'h0,        32'hFFFFFFDE, 0, 3));
    vecs.push_back(mk(0, 2'd0, 0, 32'h13, 32'h0,        32'h000000DE, 0, 3));
    vecs.push_back(mk(1, 2'd0, 0, 32'h11, 32'h55,       32'h0,        0, 4));
    vecs.push_back(mk(0, 2'd2, 0, 32'h10, 32'h0,        32'hDEAD55EF, 0, 3));
    vecs.push_back(mk(1, 2'd1, 0, 32'h12, 32'h1234,     32'h0,        0, 4));
    vecs.push_back(mk(0, 2'd2, 0, 32'h10, 32'h0,        32'h123455EF, 0, 3));
    vecs.push_back(mk(0, 2'd1, 0, 32'h11, 32'h0,        32'h123455EF, 1, 1));
    vecs.push_back(mk(1, 2'd2, 0, 32'h12, 32'hFFFFFFFF, 32'h123455EF, 1, 1));
    vecs.push_back(mk(0, 2'd2, 0, 32'h10, 32'h0,        32'h123455EF, 0, 3));
    vecs.push_back(mk(0, 2'd1, 1, 32'h12, 32'h0,        32'h00001234, 0, 3));
    vecs.push_back(mk(0, 2'd0, 1, 32'h11, 32'h0,        32'h00000055, 0, 3));
    vecs.push_back(mk(0, 2'd0, 1, 32'h10, 32'h0,        32'hFFFFFFEF, 0, 3));
    vecs.push_back(mk(1, 2'd3, 0, 32'h0,  32'hCAFEF00D, 32'h0,        0, 2));
    vecs.push_back(mk(0, 2'd3, 0, 32'h2,  32'h0,        32'hFFFFFFEF, 1, 1));

    for (int i = 0; i < (1 << AW); i++) begin
      mem_arr[i] = '0;
      ref_mem[i] = '0;
    end

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset dbg_state", {30'b0, dbg_state}, 32'd0);
    chk("reset acks/err/we", {28'b0, if_ack, d_ack, d_err, mem_we}, 32'd0);
    chk("reset mem_addr", 32'(mem_addr), 32'd0);
    chk("reset mem_din", mem_din, 32'd0);
    chk("reset if_data", if_data, 32'd0);
    chk("reset d_rdata", d_rdata, 32'd0);
    rst = 1'b0;

    // Directed table
    last_rd = '0;
    foreach (vecs[i]) begin
      int unsigned wi;
      logic [31:0] exp_word;
      string tag;
      tag = $sformatf("vec%0d", i);
      exec_data(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata, lat, rd, err, wd);
      chk({tag, " latency"}, 32'(lat), 32'(vecs[i].exp_lat));
      chk({tag, " d_err"}, {31'b0, err}, {31'b0, vecs[i].exp_err});
      chk({tag, " we pulses"}, 32'(wd), (vecs[i].we && !vecs[i].exp_err) ? 32'd1 : 32'd0);
      if (!vecs[i].we || vecs[i].exp_err) chk({tag, " rdata"}, rd, vecs[i].exp_rd);
      if (!vecs[i].we && !vecs[i].exp_err) last_rd = vecs[i].exp_rd;
      if (vecs[i].we && !vecs[i].exp_err) begin
        wi = ref_widx(vecs[i].addr);
        exp_word = ref_store(ref_mem[wi], vecs[i].size, vecs[i].addr, vecs[i].wdata);
        ref_mem[wi] = exp_word;
        chk({tag, " mem_addr"}, 32'(last_we_addr), 32'(wi));
        chk({tag, " mem_din"}, last_we_din, exp_word);
      end
    end
    chk("word 4 contents", mem_arr[4], 32'h123455EF);

    // Simultaneous requests: data first, fetch after the ack cycle
    @(posedge clk); #1;
    we0 = we_cnt;
    d_we = 1'b0; d_size = 2'd2; d_signed = 1'b0; d_addr = 32'h10; d_req = 1'b1;
    if_addr = 32'h0; if_req = 1'b1;
    dlat = -1; ilat = -1; rd = '0; fd = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (d_ack && dlat < 0) begin dlat = c; rd = d_rdata; d_req = 1'b0; end
      if (if_ack && ilat < 0) begin ilat = c; fd = if_data; if_req = 1'b0; end
      if (dlat >= 0 && ilat >= 0) break;
    end
    d_req = 1'b0; if_req = 1'b0;
    chk("arb d_ack cycle", 32'(dlat), 32'd3);
    chk("arb if_ack cycle", 32'(ilat), 32'd7);
    chk("arb d_rdata", rd, 32'h123455EF);
    chk("arb if_data", fd, 32'hCAFEF00D);
    chk("arb no we", 32'(we_cnt - we0), 32'd0);

    // Reset during WAIT of a byte store
    @(posedge clk); #1;
    we0 = we_cnt;
    abort_acks = 0;
    d_we = 1'b1; d_size = 2'd0; d_signed = 1'b0; d_addr = 32'h11; d_wdata = 32'hAA; d_req = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (d_ack) abort_acks++;
    end
    rst = 1'b1; d_req = 1'b0;
    @(negedge clk);
    chk("abort state idle", {30'b0, dbg_state}, 32'd0);
    if (d_ack) abort_acks++;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (d_ack) abort_acks++;
    end
    chk("abort no d_ack", 32'(abort_acks), 32'd0);
    chk("abort no we", 32'(we_cnt - we0), 32'd0);
    chk("abort word kept", mem_arr[4], 32'h123455EF);
    exec_fetch(32'h10, lat, fd, wd);
    chk("post-abort fetch latency", 32'(lat), 32'd3);
    chk("post-abort fetch data", fd, 32'h123455EF);
    chk("post-abort fetch no we", 32'(wd), 32'd0);

    // Randomized traffic in a small window, with occasional high-address aliasing
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      a = 32'h80 + $urandom_range(0, 63);
      if ($urandom_range(0, 3) == 0) a[31:AW+2] = $urandom;
      if ($urandom_range(0, 4) == 0) begin
        a[1:0] = 2'b00;
        exec_fetch(a, lat, fd, wd);
        chk($sformatf("rnd%0d fetch latency", n), 32'(lat), 32'd3);
        chk($sformatf("rnd%0d fetch data", n), fd, ref_mem[ref_widx(a)]);
        chk($sformatf("rnd%0d fetch no we", n), 32'(wd), 32'd0);
      end else begin
        model_data($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), a, $urandom, last_rd);
      end
    end

    repeat (2) @(negedge clk);
    chk("acks never overlap", 32'(overlap_cnt), 32'd0);
    chk("ack pulses one cycle", 32'(long_pulse_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
